// File: rtl/wb_regfile_if.sv
// Writeback, ID read and debug signals of the general-purpose register file.
// The master drives writes, read addresses and debug requests; the register file is the slave.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              wb_regWriteEn;
  logic [ADDR_W-1:0] wb_regWriteAddr;
  logic [DATA_W-1:0] wb_regWriteData;
  logic [ADDR_W-1:0] id_rsAddr;
  logic [ADDR_W-1:0] id_rtAddr;
  logic [DATA_W-1:0] id_rsData;
  logic [DATA_W-1:0] id_rtData;
  logic              dbg_reqValid;
  logic [ADDR_W-1:0] dbg_reqAddr;
  logic              dbg_rspValid;
  logic [DATA_W-1:0] dbg_rspData;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output wb_regWriteEn, wb_regWriteAddr, wb_regWriteData,
    output id_rsAddr, id_rtAddr, dbg_reqValid, dbg_reqAddr,
    input  id_rsData, id_rtData, dbg_rspValid, dbg_rspData, wr_count
  );

  modport slave (
    input  wb_regWriteEn, wb_regWriteAddr, wb_regWriteData,
    input  id_rsAddr, id_rtAddr, dbg_reqValid, dbg_reqAddr,
    output id_rsData, id_rtData, dbg_rspValid, dbg_rspData, wr_count
  );
endinterface

// File: rtl/wb_regfile.sv
// General-purpose register file: one WB write per cycle, two combinational ID read ports
// with same-cycle WB bypass, a registered debug read port and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              write_commit;
  logic              bypass_en;
  logic [CNT_W-1:0]  count_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] dbg_data;

  assign write_commit = bus.wb_regWriteEn && (bus.wb_regWriteAddr != '0);
  // Bypass is suppressed during reset so the read ports see the cleared array.
  assign bypass_en    = bus.wb_regWriteEn && !rst;

  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              byp,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (addr == '0)
      return '0;
    else if (byp && (waddr == addr))
      return wdata;
    else
      return stored;
  endfunction

  always_comb begin
    rs_data  = resolve(bus.id_rsAddr, regs[bus.id_rsAddr], bypass_en,
                       bus.wb_regWriteAddr, bus.wb_regWriteData);
    rt_data  = resolve(bus.id_rtAddr, regs[bus.id_rtAddr], bypass_en,
                       bus.wb_regWriteAddr, bus.wb_regWriteData);
    dbg_data = resolve(bus.dbg_reqAddr, regs[bus.dbg_reqAddr], bypass_en,
                       bus.wb_regWriteAddr, bus.wb_regWriteData);
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (write_commit) begin
      regs[bus.wb_regWriteAddr] <= bus.wb_regWriteData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (write_commit)
      count_q <= count_q + CNT_W'(1);
  end

  // Debug data holds its last value between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= bus.dbg_reqValid;
      if (bus.dbg_reqValid)
        rsp_data_q <= dbg_data;
    end
  end

  assign bus.id_rsData    = rs_data;
  assign bus.id_rtData    = rt_data;
  assign bus.dbg_rspValid = rsp_valid_q;
  assign bus.dbg_rspData  = rsp_data_q;
  assign bus.wr_count     = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed and random traffic checked against a
// behavioural register-file model; a narrow counter exercises wrap-around.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [CNT_W-1:0]  cnt;
  } rd_exp_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } dbg_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  rd_exp_t           rd_q[$];
  dbg_exp_t          dbg_q[$];
  logic [DATA_W-1:0] model_regs [32];
  int unsigned       model_cnt;
  logic [DATA_W-1:0] last_rsp;
  rd_exp_t           mon_rd;
  dbg_exp_t          mon_dbg;
  logic              exp_valid;

  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int addr, input bit we,
                                                   input int waddr,
                                                   input logic [DATA_W-1:0] wdata);
    if (addr == 0) return '0;
    if (we && waddr == addr) return wdata;
    return model_regs[addr];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_cnt = 0;
    last_rsp  = '0;
    rd_q.delete();
    dbg_q.delete();
  endtask

  // Called at posedge+1; drives one cycle of inputs and records what the DUT must show.
  task automatic applyStimulus(input bit we, input int waddr, input logic [DATA_W-1:0] wdata,
                               input int rs, input int rt, input bit dreq, input int daddr);
    rd_exp_t  r;
    dbg_exp_t d;
    bus.wb_regWriteEn   = we;
    bus.wb_regWriteAddr = ADDR_W'(waddr);
    bus.wb_regWriteData = wdata;
    bus.id_rsAddr       = ADDR_W'(rs);
    bus.id_rtAddr       = ADDR_W'(rt);
    bus.dbg_reqValid    = dreq;
    bus.dbg_reqAddr     = ADDR_W'(daddr);
    r.rs  = model_read(rs, we, waddr, wdata);
    r.rt  = model_read(rt, we, waddr, wdata);
    r.cnt = CNT_W'(model_cnt);
    rd_q.push_back(r);
    if (dreq) begin
      d.due  = cyc + 1;
      d.data = model_read(daddr, we, waddr, wdata);
      dbg_q.push_back(d);
    end
    if (we && waddr != 0) begin
      model_regs[waddr] = wdata;
      model_cnt = (model_cnt + 1) % (2 ** CNT_W);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares read ports every cycle and the debug port against the response queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_q.size() > 0) begin
        mon_rd = rd_q.pop_front();
        checkOutput("id_rsData", bus.id_rsData, mon_rd.rs);
        checkOutput("id_rtData", bus.id_rtData, mon_rd.rt);
        checkOutput("wr_count", bus.wr_count, mon_rd.cnt);
      end
      exp_valid = (dbg_q.size() > 0) && (dbg_q[0].due == cyc);
      checkOutput("dbg_rspValid", bus.dbg_rspValid, exp_valid);
      if (exp_valid) begin
        mon_dbg  = dbg_q.pop_front();
        last_rsp = mon_dbg.data;
      end
      checkOutput("dbg_rspData", bus.dbg_rspData, last_rsp);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int we, wa, rs, rt, dq, da;
    clearModel();
    // Reset held for two edges with a write strobe active, which must be ignored.
    rst = 1'b1;
    bus.wb_regWriteEn   = 1'b1;
    bus.wb_regWriteAddr = 5'd5;
    bus.wb_regWriteData = 32'hAAAA_5555;
    bus.id_rsAddr       = 5'd5;
    bus.id_rtAddr       = 5'd31;
    bus.dbg_reqValid    = 1'b1;
    bus.dbg_reqAddr     = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsData", bus.id_rsData, 0);
    checkOutput("reset_rtData", bus.id_rtData, 0);
    checkOutput("reset_wr_count", bus.wr_count, 0);
    checkOutput("reset_rspValid", bus.dbg_rspValid, 0);
    checkOutput("reset_rspData", bus.dbg_rspData, 0);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 5, 31, 0, 0);
    applyStimulus(1, 7, 32'hDEAD_BEEF, 7, 0, 0, 0);
    applyStimulus(0, 0, 0, 7, 0, 0, 0);
    applyStimulus(1, 0, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 32'h11, 3, 0, 0, 0);
    applyStimulus(1, 4, 32'h44, 0, 0, 0, 0);
    applyStimulus(1, 3, 32'h22, 3, 4, 0, 0);
    applyStimulus(0, 0, 0, 3, 4, 0, 0);
    applyStimulus(1, 3, 32'h99, 0, 0, 1, 7);
    applyStimulus(0, 0, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 32'h55, 0, 0, 1, 5);
    applyStimulus(1, 9, 32'hABCD, 9, 9, 1, 9);
    applyStimulus(0, 0, 0, 9, 5, 0, 0);

    for (int i = 0; i < 300; i++) begin
      we = int'($urandom_range(0, 1));
      wa = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31));
      rs = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
      rt = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
      dq = int'($urandom_range(0, 1));
      da = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
      applyStimulus(we[0], wa, $urandom, rs, rt, dq[0], da);
    end

    // Asynchronous reset between edges while a debug response is valid.
    applyStimulus(1, 7, 32'hCAFE_F00D, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 7);
    #2;
    rst = 1'b1;
    bus.wb_regWriteEn = 1'b0;
    bus.dbg_reqValid  = 1'b0;
    bus.id_rsAddr     = 5'd7;
    #1;
    checkOutput("midreset_rspValid", bus.dbg_rspValid, 0);
    checkOutput("midreset_wr_count", bus.wr_count, 0);
    checkOutput("midreset_r7", bus.id_rsData, 0);
    clearModel();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 7, 3, 1, 7);
    applyStimulus(1, 2, 32'h2222, 2, 7, 0, 0);
    applyStimulus(0, 0, 0, 2, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("dbg_queue_drained", 64'(dbg_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- General-purpose register file and the consuming end of the writeback interface driven by the MEM/WB pipeline register.
- Accepts one register write per cycle from WB.
- Serves two combinational read ports to ID, with same-cycle WB-to-ID bypass.
- Provides a registered debug read port and a retired-write counter for the testbench and on-board debug.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W registers.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_regWriteEn  in  1  write strobe from the WB stage.
- wb_regWriteAddr  in  ADDR_W  destination register.
- wb_regWriteData  in  DATA_W  write data.
- id_rsAddr  in  ADDR_W  read port A address.
- id_rtAddr  in  ADDR_W  read port B address.
- id_rsData  out  DATA_W  read port A data (combinational).
- id_rtData  out  DATA_W  read port B data (combinational).
- dbg_reqValid  in  1  debug read request.
- dbg_reqAddr  in  ADDR_W  debug read address.
- dbg_rspValid  out  1  debug response valid, one cycle after request.
- dbg_rspData  out  DATA_W  debug response data.
- wr_count  out  CNT_W  number of committed writes to non-zero registers.

Behaviour:
- Reset is asynchronous and active-high:
  - all registers 0;
  - dbg_rspValid 0, dbg_rspData 0;
  - wr_count 0.
- While rst is high:
  - no writes occur;
  - read ports return 0, since the register array is cleared;
  - no debug response is generated.
- Write commit:
  - On a rising edge with wb_regWriteEn=1 and wb_regWriteAddr!=0, the register at wb_regWriteAddr takes wb_regWriteData.
  - On the same edge, wr_count increments by 1.
- Register 0:
  - Hardwired to 0.
  - A write to address 0 is discarded and does not increment wr_count.
- wr_count wraps modulo 2**CNT_W.
- Read ports A and B are combinational, zero cycles from address to data.
  - If the address is 0, data is 0.
  - Else if wb_regWriteEn=1 and wb_regWriteAddr equals the read address, data is wb_regWriteData (bypass: ID sees the WB value in the same cycle).
  - Else data is the stored register value.
- Both read ports may hit the bypass simultaneously, on the same or different addresses; each port resolves independently.
- Debug port:
  - When dbg_reqValid=1 at a rising edge, dbg_rspValid=1 and dbg_rspData holds the value of dbg_reqAddr on the next cycle.
  - The value follows the same rules as the read ports, including bypass, evaluated at the request edge.
  - When dbg_reqValid=0, dbg_rspValid deasserts at the next edge and dbg_rspData holds its last value.
  - Back-to-back requests give back-to-back responses, one per cycle, with no stalls.
- Debug read and WB write to the same address at the same edge: the response carries the new (written) value.
- Reset asserted mid-operation: all state clears immediately, and a pending debug response is dropped (dbg_rspValid=0).
- On deassertion of rst, the first edge behaves normally. No synchronizer is required inside the block; the caller guarantees synchronous release.
- No X propagation is allowed: every output is defined from reset onward.

Test Plan:
- Reset then read: hold rst=1 for 2 cycles, release, drive id_rsAddr=5 and id_rtAddr=31 -> both data outputs 0, wr_count=0.
- Write then read:
  - Stimulus: write 0xDEADBEEF to r7, next cycle read rs=7.
  - Required: id_rsData=0xDEADBEEF and wr_count=1.
- Zero register: write 0x12345678 to r0, read rs=0 and rt=0 -> both 0; wr_count unchanged.
- Same-cycle bypass:
  - Setup: r3 holds 0x11.
  - Stimulus: in one cycle, drive wb_regWriteEn=1, wb_regWriteAddr=3, wb_regWriteData=0x22 with rs=3 and rt=4.
  - Required: id_rsData=0x22 in the same cycle, id_rtData equals r4's stored value, and r3=0x22 after the edge.
- Debug port:
  - Stimulus: requests to r7 then r3 on consecutive cycles, with r3 written with 0x99 at the first request's edge.
  - Required: responses 0xDEADBEEF then 0x99 on consecutive cycles with dbg_rspValid=1, then dbg_rspValid=0.
- Async reset mid-run:
  - Stimulus: assert rst between edges while a debug response is valid.
  - Required: dbg_rspValid drops immediately, r7 reads 0, and wr_count=0.
